write_data_fifo: RTL and testbench
==================================

WRITE_DATA_FIFO -- requirements
Module: write_data_fifo

Interface
REQ-001 Parameter WIDTH, default 8, bit width of write_data and read_data.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 write_valid  input  1  upstream presents write_data this cycle.
REQ-006 write_data  input  WIDTH  data word, sampled when write_valid && write_ready.
REQ-007 write_ready  output  1  FIFO can accept a word this cycle.
REQ-008 read_valid  output  1  read_data holds the oldest stored word.
REQ-009 read_data  output  WIDTH  oldest stored word.
REQ-010 read_ready  input  1  downstream consumes read_data when read_valid && read_ready.
REQ-011 count  output  $clog2(DEPTH+1)  number of stored words.

Function
REQ-012 Write handshake: a word SHALL be stored only on a cycle with write_valid && write_ready.
REQ-013 Read handshake: a word SHALL be removed only on a cycle with read_valid && read_ready.
REQ-014 write_ready SHALL equal (count < DEPTH); it SHALL NOT depend combinationally on read_ready.
REQ-015 read_valid SHALL equal (count > 0).
REQ-016 read_data SHALL be the word at the read pointer when read_valid is 1, and all zeros when read_valid is 0.
REQ-017 Latency: a word written into an empty FIFO SHALL appear on read_data with read_valid = 1 on the next cycle; there is no same-cycle fall-through.
REQ-018 Ordering: words SHALL be read out in write order with no loss or duplication.
REQ-019 Simultaneous write and read with 0 < count < DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-020 When full (count = DEPTH), a write SHALL be blocked even if a read completes that cycle; write_ready returns to 1 on the next cycle.
REQ-021 When empty, read_ready SHALL have no effect.
REQ-022 Write and read pointers are $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-023 count SHALL increment by 1 on a write-only cycle and decrement by 1 on a read-only cycle.
REQ-024 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-025 While rst_n = 0: pointers = 0, count = 0, read_valid = 0, read_data = 0, write_ready = 1.
REQ-026 Reset asserted mid-operation SHALL discard all stored words immediately (asynchronously).
REQ-027 Storage array contents are not reset.
REQ-028 The first handshake SHALL be accepted on the first posedge clk after rst_n deasserts.

Configuration
REQ-029 With macro WRITE_DATA_FIFO_ASSERT_EN defined, the module SHALL contain concurrent assertions, each disabled while rst_n = 0:
- !$isunknown(write_data) whenever write_valid = 1, with failure message "*** ERROR. write_data was unknown. ***"
- write_valid && !write_ready held SHALL keep write_data stable on the next cycle
- count <= DEPTH
- read_valid == (count != 0)
REQ-030 Without WRITE_DATA_FIFO_ASSERT_EN, no assertion code SHALL be compiled; functional behaviour is identical.

Structure
REQ-031 Package write_data_fifo_pkg SHALL hold:
- default constants WDF_WIDTH = 8 and WDF_DEPTH = 4
- a typedef for the count type derived from WDF_DEPTH
REQ-032 One sub-module, write_data_fifo_ptr, SHALL implement a wrap-around pointer with increment enable; it is instantiated once for the write pointer and once for the read pointer.

Verification
REQ-033 Reset, then write 0x11, 0x22, 0x33 on consecutive cycles with read_ready = 0 -> count = 3 and read_data = 0x11.
REQ-034 Write 4 words 0xA0 to 0xA3 with read_ready = 0 -> write_ready = 0 and count = 4; a fifth write of 0xA4 is not stored.
REQ-035 Full FIFO, write_valid = 1 and read_ready = 1 on the same cycle -> 0xA0 is read, the write is not accepted, and count = 3 on the next cycle.
REQ-036 count = 2, simultaneous write of 0x55 and read -> count stays 2; after draining, the output order ends with 0x55.
REQ-037 Write 10 words with read_ready = 1 continuously -> pointers wrap twice and the output sequence equals the input sequence.
REQ-038 rst_n pulsed low with count = 3 -> read_valid = 0 and count = 0 immediately; with WRITE_DATA_FIFO_ASSERT_EN defined, driving write_data = 'x while write_valid = 1 -> the assertion fires.

Source files
------------

// File: rtl/write_data_fifo_pkg.sv
// -----------------------------------------------------------------------------
// write_data_fifo_pkg
// Shared constants and types for the write-data FIFO slice.
//   WDF_WIDTH   : default data word width
//   WDF_DEPTH   : default entry count (power of two, >= 2)
//   wdf_count_t : occupancy counter type able to hold 0..WDF_DEPTH
// -----------------------------------------------------------------------------
package write_data_fifo_pkg;

    localparam int WDF_WIDTH = 8;
    localparam int WDF_DEPTH = 4;

    localparam int WDF_CNT_W = $clog2(WDF_DEPTH + 1);
    localparam int WDF_PTR_W = $clog2(WDF_DEPTH);

    typedef logic [WDF_CNT_W-1:0] wdf_count_t;
    typedef logic [WDF_PTR_W-1:0] wdf_ptr_t;

endpackage : write_data_fifo_pkg

// File: rtl/write_data_fifo_if.sv
// -----------------------------------------------------------------------------
// write_data_fifo_if
// Handshake bundle between a producer/consumer (master) and the FIFO (slave).
//   write_valid/write_data/write_ready : upstream write channel
//   read_valid/read_data/read_ready    : downstream read channel
//   count                              : current occupancy
// -----------------------------------------------------------------------------
interface write_data_fifo_if
    import write_data_fifo_pkg::*;
#(
    parameter int WIDTH = WDF_WIDTH,
    parameter int DEPTH = WDF_DEPTH
);

    logic                         write_valid;
    logic [WIDTH-1:0]             write_data;
    logic                         write_ready;
    logic                         read_valid;
    logic [WIDTH-1:0]             read_data;
    logic                         read_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Producer / consumer side
    modport master (
        output write_valid,
        output write_data,
        input  write_ready,
        input  read_valid,
        input  read_data,
        output read_ready,
        input  count
    );

    // FIFO side
    modport slave (
        input  write_valid,
        input  write_data,
        output write_ready,
        output read_valid,
        output read_data,
        input  read_ready,
        output count
    );

endinterface : write_data_fifo_if

// File: rtl/write_data_fifo_ptr.sv
// -----------------------------------------------------------------------------
// write_data_fifo_ptr
// Wrap-around index counter: advances by one when inc is high and wraps from
// DEPTH-1 back to 0.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   inc        : advance enable
//   ptr        : current index, $clog2(DEPTH) bits
// -----------------------------------------------------------------------------
module write_data_fifo_ptr
    import write_data_fifo_pkg::*;
#(
    parameter int DEPTH = WDF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_r;

    // Pointer register with explicit wrap at the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PW{1'b0}};
        end else if (inc) begin
            if (ptr_r == PW'(DEPTH - 1)) begin
                ptr_r <= {PW{1'b0}};
            end else begin
                ptr_r <= ptr_r + PW'(1);
            end
        end
    end

    assign ptr = ptr_r;

endmodule : write_data_fifo_ptr

// File: rtl/write_data_fifo.sv
// -----------------------------------------------------------------------------
// write_data_fifo
// Synchronous FIFO with valid/ready handshakes on both sides. A written word is
// visible on read_data one cycle later (no fall-through). write_ready depends
// only on registered occupancy, so a full FIFO refuses a write even on a cycle
// where a read drains an entry.
//   clk   : clock
//   rst_n : asynchronous active-low reset; discards all stored words
//   bus   : write_data_fifo_if.slave (write/read channels and count)
// Optional build macro: WRITE_DATA_FIFO_ASSERT_EN compiles in protocol and
// occupancy assertions.
// -----------------------------------------------------------------------------
module write_data_fifo
    import write_data_fifo_pkg::*;
#(
    parameter int WIDTH = WDF_WIDTH,
    parameter int DEPTH = WDF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    write_data_fifo_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             read_valid_r;
    logic             write_ready_r;
    logic             wr_en_s;
    logic             rd_en_s;
    logic [PW-1:0]    wr_ptr_s;
    logic [PW-1:0]    rd_ptr_s;
    logic [WIDTH-1:0] read_data_s;

    // Handshake qualification from registered flags only
    always_comb begin
        wr_en_s = bus.write_valid && write_ready_r;
        rd_en_s = read_valid_r && bus.read_ready;
    end

    write_data_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_en_s),
        .ptr   (wr_ptr_s)
    );

    write_data_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_en_s),
        .ptr   (rd_ptr_s)
    );

    // Next occupancy: simultaneous write and read leaves it unchanged
    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy and status flags, registered from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r       <= {CW{1'b0}};
            read_valid_r  <= 1'b0;
            write_ready_r <= 1'b1;
        end else begin
            count_r       <= count_next_s;
            read_valid_r  <= (count_next_s != {CW{1'b0}});
            write_ready_r <= (count_next_s < CW'(DEPTH));
        end
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_s] <= bus.write_data;
        end
    end

    // Output word is forced to zero whenever nothing is stored
    always_comb begin
        if (read_valid_r) begin
            read_data_s = mem_r[rd_ptr_s];
        end else begin
            read_data_s = {WIDTH{1'b0}};
        end
    end

    assign bus.write_ready = write_ready_r;
    assign bus.read_valid  = read_valid_r;
    assign bus.read_data   = read_data_s;
    assign bus.count       = count_r;

`ifdef WRITE_DATA_FIFO_ASSERT_EN
    a_write_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        bus.write_valid |-> !$isunknown(bus.write_data))
        else $error("*** ERROR. write_data was unknown. ***");

    a_write_data_held: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.write_valid && !bus.write_ready) |=> $stable(bus.write_data))
        else $error("write_data changed while a write was stalled");

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_r <= CW'(DEPTH))
        else $error("count exceeded DEPTH");

    a_read_valid_count: assert property (@(posedge clk) disable iff (!rst_n)
        read_valid_r == (count_r != {CW{1'b0}}))
        else $error("read_valid disagrees with count");
`else
`endif

endmodule : write_data_fifo

// File: tb/tb_write_data_fifo.sv
// -----------------------------------------------------------------------------
// tb_write_data_fifo
// Self-checking bench for write_data_fifo (WIDTH=8, DEPTH=4): a directed
// vector table, hand-written wrap and reset sequences, then random traffic
// checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_write_data_fifo;
    import write_data_fifo_pkg::*;

    localparam int W = WDF_WIDTH;
    localparam int D = WDF_DEPTH;

    logic clk;
    logic rst_n;

    write_data_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    write_data_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [W-1:0] model_q[$];   // reference contents, oldest at index 0
    logic [W-1:0] obs_q[$];     // words seen leaving the FIFO

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        int         exp_count;
        logic       exp_rv;
        logic [7:0] exp_rd;
        logic       exp_wr;
    } vec_t;

    vec_t tbl[17];

    task automatic check_outputs(input string tag, input int ec, input logic erv,
                                 input logic [W-1:0] erd, input logic ewr);
        vectors++;
        if (int'(bus.count) != ec || bus.read_valid !== erv ||
            bus.read_data !== erd || bus.write_ready !== ewr) begin
            miscompares++;
            $display("FAIL %s: got count=%0d read_valid=%b read_data=%02h write_ready=%b, expected count=%0d read_valid=%b read_data=%02h write_ready=%b",
                     tag, bus.count, bus.read_valid, bus.read_data, bus.write_ready,
                     ec, erv, erd, ewr);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        logic [W-1:0] head;
        n    = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        check_outputs(tag, n, n > 0, head, n < D);
    endtask

    // Drive one cycle: update the model from pre-edge state, clock, settle.
    task automatic apply(input logic wv, input logic [W-1:0] wd, input logic rr);
        bit do_w;
        bit do_r;
        bus.write_valid = wv;
        bus.write_data  = wd;
        bus.read_ready  = rr;
        #1;
        if (bus.read_valid && rr) obs_q.push_back(bus.read_data);
        do_w = wv && (model_q.size() < D);
        do_r = rr && (model_q.size() > 0);
        if (do_r) void'(model_q.pop_front());
        if (do_w) model_q.push_back(wd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] sent[$];
        logic         wv;
        logic [W-1:0] wd;
        logic         rr;
        logic         hold;

        vectors     = 0;
        miscompares = 0;

        // wv, wd, rr, count, rv, rd, wr
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11, 1'b1};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11, 1'b1};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h22, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h33, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
        tbl[7]  = '{1'b1, 8'hA0, 1'b0, 1, 1'b1, 8'hA0, 1'b1};
        tbl[8]  = '{1'b1, 8'hA1, 1'b0, 2, 1'b1, 8'hA0, 1'b1};
        tbl[9]  = '{1'b1, 8'hA2, 1'b0, 3, 1'b1, 8'hA0, 1'b1};
        tbl[10] = '{1'b1, 8'hA3, 1'b0, 4, 1'b1, 8'hA0, 1'b0};
        tbl[11] = '{1'b1, 8'hA4, 1'b0, 4, 1'b1, 8'hA0, 1'b0};
        tbl[12] = '{1'b1, 8'hA4, 1'b1, 3, 1'b1, 8'hA1, 1'b1};
        tbl[13] = '{1'b0, 8'hA4, 1'b1, 2, 1'b1, 8'hA2, 1'b1};
        tbl[14] = '{1'b1, 8'h55, 1'b1, 2, 1'b1, 8'hA3, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h55, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};

        // Reset state
        rst_n           = 1'b0;
        bus.write_valid = 1'b0;
        bus.write_data  = '0;
        bus.read_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].wv, tbl[i].wd, tbl[i].rr);
            check_outputs($sformatf("table[%0d]", i), tbl[i].exp_count,
                          tbl[i].exp_rv, tbl[i].exp_rd, tbl[i].exp_wr);
        end

        // Ten writes with continuous read: pointers wrap, order preserved
        obs_q.delete();
        sent.delete();
        for (int i = 0; i < 10; i++) begin
            wd = 8'hC0 + 8'(i);
            sent.push_back(wd);
            apply(1'b1, wd, 1'b1);
            check_model($sformatf("stream[%0d]", i));
        end
        apply(1'b0, 8'h00, 1'b1);
        check_model("stream_drain");
        vectors++;
        if (obs_q.size() != 10) begin
            miscompares++;
            $display("FAIL stream_len: got %0d words, expected 10", obs_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (obs_q[i] !== sent[i]) begin
                    miscompares++;
                    $display("FAIL stream_order[%0d]: got %02h, expected %02h",
                             i, obs_q[i], sent[i]);
                end
            end
        end

        // Asynchronous reset with three words stored
        apply(1'b1, 8'h01, 1'b0);
        apply(1'b1, 8'h02, 1'b0);
        apply(1'b1, 8'h03, 1'b0);
        check_outputs("pre_reset", 3, 1'b1, 8'h01, 1'b1);
        bus.write_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_outputs("async_reset", 0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 8'h77, 1'b0);
        check_model("first_after_reset");
        apply(1'b0, 8'h00, 1'b1);
        check_model("first_after_reset_drain");

        // Random traffic against the reference model
        hold = 1'b0;
        wv   = 1'b0;
        wd   = '0;
        for (int i = 0; i < 500; i++) begin
            if (!hold) begin
                wv = ($urandom_range(0, 99) < 60);
                wd = W'($urandom);
            end
            rr   = ($urandom_range(0, 99) < 45);
            hold = wv && !bus.write_ready;
            apply(wv, wd, rr);
            check_model($sformatf("random[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_write_data_fifo
